// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths, tracking depth, Tnew/Tuse class constants and the
// forward-select encoding used by the hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int DEPTH = 3;  // tracked stages after D (1=E ... DEPTH=W)
  localparam int NSRC  = 2;  // decode source operands (rs, rt)
  localparam int RAW   = 5;  // register address width
  localparam int TW    = 2;  // Tnew/Tuse width
  localparam int SW    = 2;  // forward-select width, 2**SW > DEPTH

  // Tnew per producer class, counted from entry into stage 1
  localparam logic [TW-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TW-1:0] TNEW_LOAD = 2'd2;
  localparam logic [TW-1:0] TNEW_LINK = 2'd0;

  // Tuse per consumer class
  localparam logic [TW-1:0] TUSE_BRANCH = 2'd0;
  localparam logic [TW-1:0] TUSE_ALU    = 2'd1;
  localparam logic [TW-1:0] TUSE_STORE  = 2'd2;

  // Select value meaning "take the register file"
  localparam logic [SW-1:0] FWD_RF = '0;

  // Tnew counts down once per advance and parks at zero
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side request and control/forwarding response bundle between the
// datapath (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic                 d_valid;
  logic                 d_we;
  logic [RAW-1:0]       d_dst;
  logic [TW-1:0]        d_tnew;
  logic [NSRC*RAW-1:0]  d_src;
  logic [NSRC*TW-1:0]   d_tuse;
  logic [NSRC-1:0]      d_src_use;
  logic                 freeze;

  logic                 pc_en;
  logic                 d_en;
  logic                 e_clr;
  logic [NSRC*SW-1:0]   fwd_sel;
  logic [NSRC-1:0]      fwd_pend;
  logic [31:0]          stall_cnt;

  modport master (
    output d_valid, d_we, d_dst, d_tnew, d_src, d_tuse, d_src_use, freeze,
    input  pc_en, d_en, e_clr, fwd_sel, fwd_pend, stall_cnt
  );

  modport slave (
    input  d_valid, d_we, d_dst, d_tnew, d_src, d_tuse, d_src_use, freeze,
    output pc_en, d_en, e_clr, fwd_sel, fwd_pend, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_stage.sv
// One tracked pipeline stage: valid, destination and remaining Tnew.
// Stages after the first count Tnew down as the entry moves in.
module hazard_scoreboard_stage
  import hazard_scoreboard_pkg::*;
#(
  parameter bit DEC = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_hold,
  input  logic           i_v,
  input  logic [RAW-1:0] i_dst,
  input  logic [TW-1:0]  i_tnew,
  output logic           o_v,
  output logic [RAW-1:0] o_dst,
  output logic [TW-1:0]  o_tnew
);

  logic           r_v;
  logic [RAW-1:0] r_dst;
  logic [TW-1:0]  r_tnew;

  // Load the upstream entry unless the pipeline is frozen
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v    <= 1'b0;
      r_dst  <= '0;
      r_tnew <= '0;
    end else if (!i_hold) begin
      r_v    <= i_v;
      r_dst  <= i_dst;
      r_tnew <= DEC ? sat_dec(i_tnew) : i_tnew;
    end
  end

  assign o_v    = r_v;
  assign o_dst  = r_dst;
  assign o_tnew = r_tnew;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: tracks in-flight producers, picks the
// youngest matching producer per decode source, and stalls D when the
// value will not be ready by the time the source is consumed.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  hs
);

  logic [DEPTH-1:0]  w_v;
  logic [RAW-1:0]    w_dst  [DEPTH];
  logic [TW-1:0]     w_tnew [DEPTH];
  logic              w_ld_v0;
  logic              w_hazard;
  logic [NSRC-1:0]   w_haz_src;
  logic [NSRC*SW-1:0] w_fwd_sel;
  logic [NSRC-1:0]   w_fwd_pend;
  logic [RAW-1:0]    w_src;
  logic              w_hit;
  logic [SW-1:0]     w_k;
  logic [TW-1:0]     w_tn;
  logic [31:0]       r_stall_cnt;

  // A stalled D becomes a bubble; writes to $0 are never tracked
  assign w_ld_v0 = ~w_hazard & hs.d_valid & hs.d_we & (hs.d_dst != '0);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      hazard_scoreboard_stage #(.DEC(1'b0)) u_stage (
        .clk    (clk),
        .reset  (reset),
        .i_hold (hs.freeze),
        .i_v    (w_ld_v0),
        .i_dst  (hs.d_dst),
        .i_tnew (hs.d_tnew),
        .o_v    (w_v[k]),
        .o_dst  (w_dst[k]),
        .o_tnew (w_tnew[k])
      );
    end else begin : g_next
      hazard_scoreboard_stage #(.DEC(1'b1)) u_stage (
        .clk    (clk),
        .reset  (reset),
        .i_hold (hs.freeze),
        .i_v    (w_v[k-1]),
        .i_dst  (w_dst[k-1]),
        .i_tnew (w_tnew[k-1]),
        .o_v    (w_v[k]),
        .o_dst  (w_dst[k]),
        .o_tnew (w_tnew[k])
      );
    end
  end

  // Per source: scan oldest to youngest so the youngest match is kept
  always_comb begin
    w_haz_src  = '0;
    w_fwd_sel  = '0;
    w_fwd_pend = '0;
    w_src      = '0;
    w_hit      = 1'b0;
    w_k        = FWD_RF;
    w_tn       = '0;
    for (int s = 0; s < NSRC; s++) begin
      w_src = hs.d_src[s*RAW +: RAW];
      w_hit = 1'b0;
      w_k   = FWD_RF;
      w_tn  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (hs.d_src_use[s] && w_v[k] && (w_dst[k] == w_src) && (w_src != '0)) begin
          w_hit = 1'b1;
          w_k   = SW'(k + 1);
          w_tn  = w_tnew[k];
        end
      end
      if (w_hit) begin
        if (w_tn == '0)
          w_fwd_sel[s*SW +: SW] = w_k;
        else if (w_tn <= hs.d_tuse[s*TW +: TW])
          w_fwd_pend[s] = 1'b1;
        else
          w_haz_src[s] = 1'b1;
      end
    end
  end

  assign w_hazard    = hs.d_valid & (|w_haz_src);
  assign hs.pc_en    = ~(w_hazard | hs.freeze);
  assign hs.d_en     = ~(w_hazard | hs.freeze);
  assign hs.e_clr    = w_hazard & ~hs.freeze;
  assign hs.fwd_sel  = w_fwd_sel;
  assign hs.fwd_pend = w_fwd_pend;
  assign hs.stall_cnt = r_stall_cnt;

  // Count cycles actually lost to hazards; saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (!hs.freeze && w_hazard && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

endmodule
